// File: rtl/syn_calc_par.sv
// BCH syndrome calculator: evaluates r(alpha^j), j=1..2t, over GF(2^m) by Horner's rule, P bits per cycle.
// Optional feature macro SYN_CALC_ZFLAG_EN adds the zero_syn output.
module syn_calc_par #(
    parameter int N_MAX = 1023,
    parameter int T_MAX = 4,
    parameter int M_MAX = 10,
    parameter int P     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [9:0]                 n,
    input  logic [3:0]                 t,
    input  logic [3:0]                 m,
    input  logic [N_MAX-1:0]           hard_bits,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
`ifdef SYN_CALC_ZFLAG_EN
    output logic                       zero_syn,
`endif
    output logic [2*T_MAX*M_MAX-1:0]   syndromes
);

    localparam int NS = 2 * T_MAX;
    localparam int SW = NS * M_MAX;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [9:0]         idx_q, idx_d;
    logic [3:0]         t_q, t_d;
    logic [3:0]         m_q, m_d;
    logic [M_MAX-1:0]   acc_q [NS];
    logic [M_MAX-1:0]   acc_d [NS];
    logic [SW-1:0]      syn_q, syn_d;
    logic               err_q, err_d;
    logic               params_ok;

    function automatic logic [M_MAX-1:0] field_mask(input logic [3:0] mm);
        logic [M_MAX-1:0] r;
        r = '0;
        for (int i = 0; i < M_MAX; i++)
            if (i < int'(mm)) r[i] = 1'b1;
        return r;
    endfunction

    // Low-order terms of the primitive polynomial; the x^m term is implied by the shift-out bit.
    function automatic logic [M_MAX-1:0] poly_low(input logic [3:0] mm);
        case (mm)
            4'd4:    return M_MAX'(10'h003);
            4'd5:    return M_MAX'(10'h005);
            4'd6:    return M_MAX'(10'h003);
            4'd7:    return M_MAX'(10'h009);
            4'd8:    return M_MAX'(10'h01D);
            4'd9:    return M_MAX'(10'h011);
            4'd10:   return M_MAX'(10'h009);
            default: return '0;
        endcase
    endfunction

    function automatic logic [M_MAX-1:0] mul_alpha(input logic [M_MAX-1:0] x, input logic [3:0] mm);
        logic [M_MAX:0] sh;
        sh = {x, 1'b0};
        return (sh[M_MAX-1:0] & field_mask(mm)) ^ (sh[mm] ? poly_low(mm) : '0);
    endfunction

    function automatic logic [M_MAX-1:0] mul_alpha_pow(input logic [M_MAX-1:0] x, input int j,
                                                       input logic [3:0] mm);
        logic [M_MAX-1:0] r;
        r = x;
        for (int k = 0; k < NS; k++)
            if (k < j) r = mul_alpha(r, mm);
        return r;
    endfunction

    function automatic logic [SW-1:0] pack_syn(input logic [M_MAX-1:0] a [NS], input logic [3:0] tt,
                                               input logic [3:0] mm);
        logic [SW-1:0] r;
        r = '0;
        for (int j = 0; j < NS; j++)
            if (j < 2 * int'(tt)) r[j*M_MAX +: M_MAX] = a[j] & field_mask(mm);
        return r;
    endfunction

    assign params_ok = (m >= 4'd4) && (int'(m) <= M_MAX) && (t != 4'd0) && (int'(t) <= T_MAX)
                    && (int'(n) <= (1 << m) - 1);

    // NOTE: every signal written here gets a default first, so no path leaves one unassigned
    // and infers a latch; blocking assignments let later stages see earlier stage results.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        t_d     = t_q;
        m_d     = m_q;
        acc_d   = acc_q;
        syn_d   = syn_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (!params_ok) begin
                        state_d = DONE;
                        syn_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        t_d     = t;
                        m_d     = m;
                        idx_d   = n;
                        acc_d   = '{default: '0};
                        if (n == 10'd0) begin
                            state_d = DONE;
                            syn_d   = '0;
                            err_d   = 1'b0;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
            end
            RUN: begin
                // Stages past bit 0 pass through, so a short final chunk needs no padding.
                for (int s = 0; s < P; s++) begin
                    if (idx_q > 10'(s)) begin
                        for (int j = 0; j < NS; j++)
                            acc_d[j] = mul_alpha_pow(acc_d[j], j + 1, m_q)
                                     ^ M_MAX'(hard_bits[idx_q - 10'(s + 1)]);
                    end
                end
                idx_d = (idx_q > 10'(P)) ? idx_q - 10'(P) : '0;
                if (idx_d == 10'd0) begin
                    state_d = DONE;
                    syn_d   = pack_syn(acc_d, t_q, m_q);
                    err_d   = 1'b0;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; the small accumulator array is reset
    // like any other register since the outputs must read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            t_q     <= '0;
            m_q     <= '0;
            acc_q   <= '{default: '0};
            syn_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            t_q     <= t_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            syn_q   <= syn_d;
            err_q   <= err_d;
        end
    end

`ifdef SYN_CALC_ZFLAG_EN
    logic zero_q;
    always_ff @(posedge clk) begin
        if (rst)
            zero_q <= 1'b0;
        else if (state_q != DONE && state_d == DONE)
            zero_q <= !err_d && (syn_d == '0);
    end
    assign zero_syn = zero_q;
`endif

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign err       = err_q;
    assign syndromes = syn_q;

endmodule

// File: tb/tb_syn_calc_par.sv
// Bench for syn_calc_par: GF(2^m) power-table reference model, per-cycle compare process, random jobs.
module tb_syn_calc_par;

    localparam int N_MAX = 1023;
    localparam int T_MAX = 4;
    localparam int M_MAX = 10;
    localparam int P     = 8;
    localparam int NS    = 2 * T_MAX;
    localparam int SW    = NS * M_MAX;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [9:0]         n;
    logic [3:0]         t;
    logic [3:0]         m;
    logic [N_MAX-1:0]   hard_bits;
    logic               busy, done, err;
    logic [SW-1:0]      syndromes;
`ifdef SYN_CALC_ZFLAG_EN
    logic               zero_syn;
`endif

    syn_calc_par #(.N_MAX(N_MAX), .T_MAX(T_MAX), .M_MAX(M_MAX), .P(P)) dut (
        .clk(clk), .rst(rst), .start(start), .n(n), .t(t), .m(m), .hard_bits(hard_bits),
        .busy(busy), .done(done), .err(err),
`ifdef SYN_CALC_ZFLAG_EN
        .zero_syn(zero_syn),
`endif
        .syndromes(syndromes));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Model state shared with the compare process.
    int            exp_tab [11][1023];
    bit            chk_en  = 1'b0;
    bit            active  = 1'b0;
    int            acc_cyc = 0;
    int            cur_lat = 0;
    logic [SW-1:0] job_syn, old_syn;
    logic          job_err, old_err, job_zero, old_zero;

    task automatic check(input string name, input logic [SW-1:0] got, input logic [SW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, got, want);
        end
    endtask

    function automatic int full_poly(input int mm);
        case (mm)
            4: return 'h13;  5: return 'h25;  6: return 'h43;  7: return 'h89;
            8: return 'h11D; 9: return 'h211; 10: return 'h409;
            default: return 0;
        endcase
    endfunction

    function automatic bit params_valid(input int nn, input int tt, input int mm);
        return mm >= 4 && mm <= M_MAX && tt >= 1 && tt <= T_MAX && nn <= (1 << mm) - 1;
    endfunction

    // S_j = sum over set bits i < n of alpha^(i*j), read straight from the power table.
    function automatic logic [SW-1:0] model_syn(input int nn, input int tt, input int mm,
                                                input logic [N_MAX-1:0] bits);
        logic [SW-1:0] r;
        int q, s;
        r = '0;
        if (!params_valid(nn, tt, mm)) return r;
        q = (1 << mm) - 1;
        for (int j = 1; j <= 2 * tt; j++) begin
            s = 0;
            for (int i = 0; i < nn; i++)
                if (bits[i]) s = s ^ exp_tab[mm][(i * j) % q];
            r[(j-1)*M_MAX +: M_MAX] = s[M_MAX-1:0];
        end
        return r;
    endfunction

    function automatic logic [SW-1:0] pack_pin(input int v [NS]);
        logic [SW-1:0] r;
        for (int j = 0; j < NS; j++) r[j*M_MAX +: M_MAX] = v[j][M_MAX-1:0];
        return r;
    endfunction

    // Per-cycle compare of every output against the model's timeline.
    always @(negedge clk) begin
        int d;
        logic [SW-1:0] e_syn;
        logic e_err, e_zero;
        if (chk_en) begin
            d = cyc - acc_cyc;
            check("busy", SW'(busy), SW'(active && d >= 1 && d <= cur_lat));
            check("done", SW'(done), SW'(active && d == cur_lat));
            if (active && d >= cur_lat) begin
                e_syn = job_syn; e_err = job_err; e_zero = job_zero;
            end else begin
                e_syn = old_syn; e_err = old_err; e_zero = old_zero;
            end
            check("syndromes", syndromes, e_syn);
            check("err", SW'(err), SW'(e_err));
`ifdef SYN_CALC_ZFLAG_EN
            check("zero_syn", SW'(zero_syn), SW'(e_zero));
`else
            e_zero = 1'b0;
`endif
        end
    end

    task automatic set_job(input int nn, input int tt, input int mm, input logic [N_MAX-1:0] bits);
        bit v;
        v        = params_valid(nn, tt, mm);
        job_syn  = model_syn(nn, tt, mm, bits);
        job_err  = !v;
        job_zero = v && (job_syn == '0);
        cur_lat  = (!v || nn == 0) ? 1 : (nn + P - 1) / P + 1;
        n = nn[9:0]; t = tt[3:0]; m = mm[3:0]; hard_bits = bits;
        start   = 1'b1;
        acc_cyc = cyc;
        active  = 1'b1;
    endtask

    // ign_at: cycle (after accept) at which a stray start with scrambled n/t/m is pulsed.
    // poke: also pulse start during the done cycle.
    task automatic run_job(input int nn, input int tt, input int mm, input logic [N_MAX-1:0] bits,
                           input int ign_at, input bit poke);
        int d;
        @(posedge clk); #1;
        set_job(nn, tt, mm, bits);
        d = 0;
        while (d <= cur_lat) begin
            @(posedge clk); #1;
            d = cyc - acc_cyc;
            start = (d == ign_at) || (poke && d == cur_lat);
            if (d == ign_at) begin
                n = 10'($urandom); t = 4'($urandom); m = 4'($urandom);
            end
        end
        start    = 1'b0;
        active   = 1'b0;
        old_syn  = job_syn;
        old_err  = job_err;
        old_zero = job_zero;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [N_MAX-1:0] bits;
        int v;
        int nn, tt, mm, mode;

        for (int k = 4; k <= 10; k++) begin
            v = 1;
            for (int e = 0; e < (1 << k) - 1; e++) begin
                exp_tab[k][e] = v;
                v = v << 1;
                if ((v >> k) & 1) v = v ^ full_poly(k);
            end
        end

        rst = 1'b1; start = 1'b0; n = '0; t = '0; m = '0; hard_bits = '0;
        old_syn = '0; old_err = 1'b0; old_zero = 1'b0;
        job_syn = '0; job_err = 1'b0; job_zero = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        check("rst_busy", SW'(busy), '0);
        check("rst_syn", syndromes, '0);

        // Hand-computed pins on the model itself.
        bits = '0; bits[1] = 1'b1;
        check("pin_r_x", model_syn(15, 4, 4, bits), pack_pin('{2, 4, 8, 3, 6, 12, 11, 5}));
        bits = '0; bits[0] = 1'b1;
        check("pin_r_1", model_syn(15, 2, 4, bits), pack_pin('{1, 1, 1, 1, 0, 0, 0, 0}));
        bits = '0; bits[1022] = 1'b1;
        check("pin_s1_m10", SW'(model_syn(1023, 4, 10, bits) & SW'(10'h3FF)), SW'(10'h204));

        run_job(15, 4, 4, '0, -1, 1'b0);
        bits = '0; bits[1] = 1'b1;
        run_job(15, 4, 4, bits, -1, 1'b0);
        bits = '0; bits[0] = 1'b1;
        run_job(15, 2, 4, bits, -1, 1'b0);
        run_job(13, 2, 4, bits, -1, 1'b1);
        repeat (2) @(posedge clk);

        // Invalid parameter sets, then n=0.
        run_job(15, 4, 3, bits, -1, 1'b0);
        run_job(15, 5, 4, bits, -1, 1'b0);
        run_job(16, 4, 4, bits, -1, 1'b0);
        run_job(15, 0, 4, bits, -1, 1'b0);
        run_job(15, 4, 11, bits, -1, 1'b1);
        run_job(0, 3, 6, bits, -1, 1'b0);

        bits = '0; bits[1022] = 1'b1;
        run_job(1023, 4, 10, bits, 50, 1'b0);

        // Reset five cycles into a long job: no done, outputs cleared.
        @(posedge clk); #1;
        bits = '0; bits[700] = 1'b1; bits[3] = 1'b1;
        set_job(1023, 4, 10, bits);
        @(posedge clk); #1;
        start = 1'b0;
        while (cyc - acc_cyc < 5) begin
            @(posedge clk); #1;
        end
        chk_en = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        active = 1'b0; old_syn = '0; old_err = 1'b0; old_zero = 1'b0;
        chk_en = 1'b1;
        check("abort_busy", SW'(busy), '0);
        check("abort_syn", syndromes, '0);
        repeat (140) @(posedge clk);
        #1;
        run_job(1023, 4, 10, bits, 7, 1'b1);

        for (int k = 0; k < 25; k++) begin
            if ($urandom_range(0, 4) == 0) begin
                mm = $urandom_range(0, 15); tt = $urandom_range(0, 15); nn = $urandom_range(0, 1023);
            end else begin
                mm = $urandom_range(4, 10); tt = $urandom_range(1, 4); nn = $urandom_range(0, (1 << mm) - 1);
            end
            mode = $urandom_range(0, 2);
            for (int i = 0; i < N_MAX; i++) bits[i] = 1'($urandom_range(0, 1));
            if (mode == 1) begin
                for (int i = 0; i < nn; i++) bits[i] = 1'b0;
            end else if (mode == 2) begin
                bits = '0;
                if (nn > 0) bits[$urandom_range(0, nn - 1)] = 1'b1;
            end
            run_job(nn, tt, mm, bits, $urandom_range(1, 20), 1'($urandom_range(0, 1)));
        end

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
